reg_write_master: RTL and testbench

Initiator side of the config register-map write interface. Parses register-write records from a byte stream and issues one handshaked write per record into `config_reg_map`. The byte stream comes from the Ethernet RX payload path. The block also reports per-write outcome counters for host-side status.

---
 rtl/reg_write_master_pkg.sv | 24 ++
 rtl/reg_write_master_rec_assembler.sv | 53 +++++
 rtl/reg_write_master.sv | 143 ++++++++++++++
 tb/tb_reg_write_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_master_pkg.sv
// Shared types and constants for the register-write initiator (reg_write_master).
// The optional retry feature is enabled by defining REG_WR_RETRY_EN.
package reg_wr_pkg;

  typedef enum logic [1:0] {
    COLLECT    = 2'd0,
    WAIT_READY = 2'd1,
    ISSUE      = 2'd2,
    WAIT_RESP  = 2'd3
  } state_e;

  localparam int RECORD_BYTES = 9;
  localparam int REC_W        = RECORD_BYTES * 8;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_KEEP0 = 2'b01;
  localparam logic [1:0] ERR_KEEP1 = 2'b10;
  localparam logic [1:0] ERR_ADDR  = 2'b11;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/reg_write_master_rec_assembler.sv
// Byte-to-record assembler: shifts accepted bytes into a 9-byte record,
// flags completion on the last byte and truncation when tlast arrives early.
module reg_wr_rec_assembler
  import reg_wr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tdata,
  input  logic        tvalid,
  input  logic        tlast,
  input  logic        en,
  output logic [7:0]  rec_addr,
  output logic [31:0] rec_data,
  output logic [31:0] rec_keep,
  output logic        rec_done,
  output logic        short_rec,
  output logic [3:0]  idx_nxt
);

  logic [3:0]       idx;
  logic [REC_W-1:0] shreg;
  logic             accept;
  logic             last_byte;

  assign accept    = tvalid & en;
  assign last_byte = (idx == 4'(RECORD_BYTES - 1));
  assign rec_done  = accept & last_byte;
  assign short_rec = accept & tlast & ~last_byte;

  always_comb begin
    idx_nxt = idx;
    if (accept) begin
      if (last_byte || tlast) idx_nxt = 4'd0;
      else                    idx_nxt = idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= 4'd0;
      shreg <= '0;
    end else begin
      idx <= idx_nxt;
      if (accept) shreg <= {shreg[REC_W-9:0], tdata};
    end
  end

  // Oldest byte ends up on top: address, then data and keep MSB-first.
  assign rec_addr = shreg[71:64];
  assign rec_data = shreg[63:32];
  assign rec_keep = shreg[31:0];

endmodule

// File: rtl/reg_write_master.sv
// Register-write initiator: parses records from a byte stream and issues one
// handshaked write per record. Optional resend of keep errors: REG_WR_RETRY_EN.
module reg_write_master
  import reg_wr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
`ifdef REG_WR_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        wr_cmd,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] wr_keep,
  input  logic        wr_ready,
  input  logic        wr_valid,
  input  logic [1:0]  wr_err,
  output logic        busy,
  output logic [15:0] wr_ok_count,
  output logic [15:0] wr_err_count,
  output logic [1:0]  last_err,
  output logic        timeout_err,
  output logic        short_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Stream handshake: a byte transfers on a rising edge where tvalid and
  // tready are both high; tready is high only in COLLECT.
  state_e        state, state_nxt;
  logic [7:0]    rec_addr;
  logic [31:0]   rec_data, rec_keep;
  logic          rec_done, short_rec;
  logic [3:0]    idx_nxt;
  logic [TW-1:0] tmo;
  logic          resp_err, ok_evt, tmo_evt, fail_evt, retry_evt;

  reg_wr_rec_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .tdata     (s_axis_tdata),
    .tvalid    (s_axis_tvalid),
    .tlast     (s_axis_tlast),
    .en        (s_axis_tready),
    .rec_addr  (rec_addr),
    .rec_data  (rec_data),
    .rec_keep  (rec_keep),
    .rec_done  (rec_done),
    .short_rec (short_rec),
    .idx_nxt   (idx_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT:    if (rec_done) state_nxt = WAIT_READY;
      WAIT_READY: if (wr_ready) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT_RESP;
      WAIT_RESP: begin
        if (retry_evt)                             state_nxt = WAIT_READY;
        else if (resp_err || ok_evt || tmo_evt)    state_nxt = COLLECT;
      end
      default:    state_nxt = COLLECT;
    endcase
  end

  // Response decode; an error code wins over wr_valid, a response wins over
  // the timeout in the same cycle.
  always_comb begin
    resp_err = 1'b0;
    ok_evt   = 1'b0;
    tmo_evt  = 1'b0;
    fail_evt = 1'b0;
    if (state == WAIT_RESP) begin
      resp_err = (wr_err != ERR_NONE);
      ok_evt   = !resp_err && wr_valid;
      tmo_evt  = !resp_err && !wr_valid && (tmo == TW'(1));
      fail_evt = (resp_err && !retry_evt) || tmo_evt;
    end
  end

`ifdef REG_WR_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_cnt;

  assign retry_evt = resp_err && ((wr_err == ERR_KEEP0) || (wr_err == ERR_KEEP1))
                     && (retry_cnt < RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 retry_cnt <= '0;
    else if (state == COLLECT)  retry_cnt <= '0;
    else if (retry_evt)         retry_cnt <= retry_cnt + 1'b1;
  end
`else
  assign retry_evt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_tready <= 1'b1;
      busy          <= 1'b0;
      wr_cmd        <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_keep       <= '0;
      wr_ok_count   <= '0;
      wr_err_count  <= '0;
      last_err      <= ERR_NONE;
      timeout_err   <= 1'b0;
      short_err     <= 1'b0;
      tmo           <= '0;
    end else begin
      s_axis_tready <= (state_nxt == COLLECT);
      busy          <= (state_nxt != COLLECT) || (idx_nxt != 4'd0);
      wr_cmd        <= (state_nxt == ISSUE);
      timeout_err   <= tmo_evt;
      short_err     <= short_rec;
      if (state == WAIT_READY) begin
        wr_addr <= rec_addr;
        wr_data <= rec_data;
        wr_keep <= rec_keep;
        tmo     <= TW'(TIMEOUT_CYCLES);
      end else if (((state == ISSUE) || (state == WAIT_RESP)) && (tmo != '0)) begin
        tmo <= tmo - 1'b1;
      end
      if (ok_evt)   wr_ok_count  <= sat_inc(wr_ok_count);
      if (fail_evt) wr_err_count <= sat_inc(wr_err_count);
      if (resp_err) last_err     <= wr_err;
    end
  end

endmodule

// File: tb/tb_reg_write_master.sv
// Self-checking bench for reg_write_master: vector table plus hand sequences,
// with a scoreboard of expected {addr,data,keep} per write command.
module tb_reg_write_master;
  import reg_wr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        wr_cmd;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data, wr_keep;
  logic        wr_ready = 1'b1;
  logic        wr_valid;
  logic [1:0]  wr_err;
  logic        busy;
  logic [15:0] wr_ok_count, wr_err_count;
  logic [1:0]  last_err;
  logic        timeout_err, short_err;

  reg_write_master dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_data(wr_data), .wr_keep(wr_keep),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_err(wr_err),
    .busy(busy), .wr_ok_count(wr_ok_count), .wr_err_count(wr_err_count),
    .last_err(last_err), .timeout_err(timeout_err), .short_err(short_err)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [71:0] exp_q[$];
  int n_cmp = 0, n_fail = 0;
  int cmd_cnt = 0, tmo_cnt = 0, short_cnt = 0;
  int cmd_cyc = 0, tmo_cyc = 0, hs_cyc = 0;
  logic prev_cmd = 1'b0;

  function automatic void check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (wr_cmd) begin
      cmd_cnt++;
      cmd_cyc = cyc;
      check("cmd_single_cycle", 72'(prev_cmd), 72'(0));
      check("tready_low_during_write", 72'(s_axis_tready), 72'(0));
      if (exp_q.size() == 0) check("unexpected_cmd", {wr_addr, wr_data, wr_keep}, 72'hX);
      else check("cmd_addr_data_keep", {wr_addr, wr_data, wr_keep}, exp_q.pop_front());
    end
    if (timeout_err) begin tmo_cnt++; tmo_cyc = cyc; end
    if (short_err) short_cnt++;
    prev_cmd = wr_cmd;
  end

  // ---------------- register-map responder ----------------
  logic       resp_en = 1'b1;
  logic [1:0] resp_code = ERR_NONE;
  int         resp_delay = 3;

  initial begin
    wr_valid = 1'b0;
    wr_err   = ERR_NONE;
    forever begin
      @(negedge clk);
      if (wr_cmd && resp_en) begin
        repeat (resp_delay) @(negedge clk);
        wr_valid = 1'b1;
        wr_err   = resp_code;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_err   = ERR_NONE;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (!s_axis_tready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("tready_wait_bound", 72'(0), 72'(1));
    hs_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic send_rec(input logic [7:0] a, input logic [31:0] d, input logic [31:0] k,
                          input int nb, input logic last_on_end);
    logic [71:0] r;
    r = {a, d, k};
    for (int i = 0; i < nb; i++) send_byte(r[71 - 8*i -: 8], last_on_end && (i == nb - 1));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) check("idle_wait_bound", 72'(0), 72'(1));
    repeat (3) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] keep;
    logic [1:0]  err;
    int          delay;
    logic [15:0] ok;
    logic [15:0] errc;
    logic [1:0]  last;
  } vec_t;

  vec_t vecs[5];
  logic [15:0] exp_ok, exp_errc;
  logic [1:0]  exp_last;
  int c0, t0, s0;

  initial begin
    vecs[0] = '{8'h05, 32'h0000_0014, 32'hFFFF_FFF0, ERR_NONE, 3,  16'd1, 16'd0, ERR_NONE};
    vecs[1] = '{8'h00, 32'hA5A5_A5A5, 32'h0000_FFFF, ERR_NONE, 1,  16'd2, 16'd0, ERR_NONE};
    vecs[2] = '{8'h7F, 32'h1234_5678, 32'hFFFF_FFFF, ERR_ADDR, 2,  16'd2, 16'd1, ERR_ADDR};
    vecs[3] = '{8'hFF, 32'hDEAD_BEEF, 32'h0000_0000, ERR_NONE, 5,  16'd3, 16'd1, ERR_ADDR};
    vecs[4] = '{8'h3C, 32'hCAFE_F00D, 32'hF0F0_F0F0, ERR_NONE, 63, 16'd4, 16'd1, ERR_ADDR};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tready", 72'(s_axis_tready), 72'(1));
    check("rst_cmd", 72'(wr_cmd), 72'(0));
    check("rst_addr_data_keep", {wr_addr, wr_data, wr_keep}, 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_counts", {wr_ok_count, wr_err_count, last_err}, 72'(0));
    check("rst_pulses", {timeout_err, short_err}, 72'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven single records
    for (int i = 0; i < 5; i++) begin
      resp_code  = vecs[i].err;
      resp_delay = vecs[i].delay;
      exp_q.push_back({vecs[i].addr, vecs[i].data, vecs[i].keep});
      send_rec(vecs[i].addr, vecs[i].data, vecs[i].keep, 9, 1'b1);
      wait_idle();
      check("latency_cmd_after_last_byte", 72'(cmd_cyc - hs_cyc), 72'(2));
      check("ok_count", 72'(wr_ok_count), 72'(vecs[i].ok));
      check("err_count", 72'(wr_err_count), 72'(vecs[i].errc));
      check("last_err", 72'(last_err), 72'(vecs[i].last));
    end
    check("addr_hold_after_write", {wr_addr, wr_data, wr_keep}, {vecs[4].addr, vecs[4].data, vecs[4].keep});
    exp_ok = 16'd4; exp_errc = 16'd1; exp_last = ERR_ADDR;

    // three back-to-back records in one packet
    resp_code = ERR_NONE; resp_delay = 2; c0 = cmd_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back({8'(i), 32'h1000_0000 + 32'(i), 32'hFFFF_FFFF});
    for (int i = 0; i < 3; i++) send_rec(8'(i), 32'h1000_0000 + 32'(i), 32'hFFFF_FFFF, 9, i == 2);
    wait_idle();
    exp_ok = exp_ok + 16'd3;
    check("b2b_cmd_count", 72'(cmd_cnt - c0), 72'(3));
    check("b2b_ok_count", 72'(wr_ok_count), 72'(exp_ok));

    // truncated record then a good one
    c0 = cmd_cnt; s0 = short_cnt;
    send_rec(8'h44, 32'h5555_6666, 32'h7777_8888, 6, 1'b1);
    repeat (5) @(negedge clk);
    check("short_err_pulse", 72'(short_cnt - s0), 72'(1));
    check("short_no_cmd", 72'(cmd_cnt - c0), 72'(0));
    check("short_idle", 72'(busy), 72'(0));
    exp_q.push_back({8'h21, 32'h0BAD_CAFE, 32'h00FF_00FF});
    send_rec(8'h21, 32'h0BAD_CAFE, 32'h00FF_00FF, 9, 1'b1);
    wait_idle();
    exp_ok = exp_ok + 16'd1;
    check("after_short_ok_count", 72'(wr_ok_count), 72'(exp_ok));

    // keep error: retried only when the retry feature is built in
    resp_code = ERR_KEEP0; resp_delay = 2; c0 = cmd_cnt;
`ifdef REG_WR_RETRY_EN
    repeat (4) exp_q.push_back({8'h66, 32'h0000_00AA, 32'h0000_000F});
    send_rec(8'h66, 32'h0000_00AA, 32'h0000_000F, 9, 1'b1);
    wait_idle();
    check("keep_err_cmd_count", 72'(cmd_cnt - c0), 72'(4));
`else
    exp_q.push_back({8'h66, 32'h0000_00AA, 32'h0000_000F});
    send_rec(8'h66, 32'h0000_00AA, 32'h0000_000F, 9, 1'b1);
    wait_idle();
    check("keep_err_cmd_count", 72'(cmd_cnt - c0), 72'(1));
`endif
    exp_errc = exp_errc + 16'd1; exp_last = ERR_KEEP0;
    check("keep_err_count", 72'(wr_err_count), 72'(exp_errc));
    check("keep_last_err", 72'(last_err), 72'(exp_last));
    check("keep_ok_unchanged", 72'(wr_ok_count), 72'(exp_ok));

    // no response at all: timeout 64 cycles after wr_cmd
    resp_en = 1'b0; t0 = tmo_cnt;
    exp_q.push_back({8'h90, 32'h1111_2222, 32'h3333_4444});
    send_rec(8'h90, 32'h1111_2222, 32'h3333_4444, 9, 1'b1);
    wait_idle();
    exp_errc = exp_errc + 16'd1;
    check("timeout_pulse_count", 72'(tmo_cnt - t0), 72'(1));
    check("timeout_delay", 72'(tmo_cyc - cmd_cyc), 72'(64));
    check("timeout_err_count", 72'(wr_err_count), 72'(exp_errc));
    resp_en = 1'b1;

    // response in the wr_cmd cycle itself is ignored and times out
    resp_code = ERR_NONE; resp_delay = 0; t0 = tmo_cnt;
    exp_q.push_back({8'h91, 32'h0F0F_0F0F, 32'hFFFF_0000});
    send_rec(8'h91, 32'h0F0F_0F0F, 32'hFFFF_0000, 9, 1'b1);
    wait_idle();
    exp_errc = exp_errc + 16'd1;
    check("coincident_resp_timeout", 72'(tmo_cnt - t0), 72'(1));
    check("coincident_ok_unchanged", 72'(wr_ok_count), 72'(exp_ok));
    check("coincident_err_count", 72'(wr_err_count), 72'(exp_errc));

    // wr_ready low for 100 cycles delays wr_cmd by exactly that much
    resp_delay = 4; wr_ready = 1'b0;
    exp_q.push_back({8'hA0, 32'h8765_4321, 32'h0000_0001});
    send_rec(8'hA0, 32'h8765_4321, 32'h0000_0001, 9, 1'b1);
    repeat (100) @(negedge clk);
    wr_ready = 1'b1;
    wait_idle();
    exp_ok = exp_ok + 16'd1;
    check("ready_low_delay", 72'(cmd_cyc - hs_cyc), 72'(102));
    check("ready_low_ok_count", 72'(wr_ok_count), 72'(exp_ok));

    // reset in the middle of a record
    send_rec(8'hB0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_counts", {wr_ok_count, wr_err_count, last_err}, 72'(0));
    check("midrst_busy_tready", {busy, s_axis_tready}, 72'(1));
    rst_n = 1'b1;
    @(negedge clk);
    c0 = cmd_cnt;
    send_rec(8'hB1, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0);
    repeat (20) @(negedge clk);
    check("midrst_no_cmd", 72'(cmd_cnt - c0), 72'(0));
    check("midrst_partial_busy", 72'(busy), 72'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({8'hC3, 32'h0000_0014, 32'hFFFF_FFF0});
    send_rec(8'hC3, 32'h0000_0014, 32'hFFFF_FFF0, 9, 1'b1);
    wait_idle();
    check("post_reset_ok_count", 72'(wr_ok_count), 72'(1));
    check("post_reset_err_count", 72'(wr_err_count), 72'(0));

    check("scoreboard_drained", 72'(exp_q.size()), 72'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
